// File: rtl/pixel_cache_pkg.sv
// Shared types and address helpers for the packed 1bpp pixel word cache.
package pixel_cache_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE
  } state_e;

  // Word holding pixel (x,y) in a row-major image packed word_w pixels per word.
  function automatic logic [31:0] word_addr(input logic [31:0] x, input logic [31:0] y,
                                            input int img_w, input int word_w);
    return y * 32'(img_w / word_w) + x / 32'(word_w);
  endfunction

  // Pixel 0 of each word sits in the MSB.
  function automatic logic [31:0] bit_index(input logic [31:0] x, input int word_w);
    return 32'(word_w - 1) - (x % 32'(word_w));
  endfunction

endpackage

// File: rtl/pixel_cache_line_store.sv
// Fully associative word store: parallel tag match, single-slot install, bulk invalidate.
module pixel_cache_line_store #(
  parameter int NUM_LINES = 4,
  parameter int WORD_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int IDX_W     = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] lookup_tag_i,
  output logic              hit_o,
  output logic [WORD_W-1:0] hit_data_o,
  input  logic              flush_i,
  input  logic              install_i,
  input  logic [IDX_W-1:0]  install_idx_i,
  input  logic [ADDR_W-1:0] install_tag_i,
  input  logic [WORD_W-1:0] install_data_i
);

  logic [NUM_LINES-1:0] valid_q;
  logic [ADDR_W-1:0]    tag_q  [NUM_LINES];
  logic [WORD_W-1:0]    data_q [NUM_LINES];

  // Tags are unique among valid lines, so at most one slot can match.
  always_comb begin
    hit_o      = 1'b0;
    hit_data_o = '0;
    for (int i = 0; i < NUM_LINES; i++) begin
      if (valid_q[i] && (tag_q[i] == lookup_tag_i)) begin
        hit_o      = 1'b1;
        hit_data_o = data_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_LINES; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else if (flush_i) begin
      valid_q <= '0;
    end else if (install_i) begin
      valid_q[install_idx_i] <= 1'b1;
      tag_q[install_idx_i]   <= install_tag_i;
      data_q[install_idx_i]  <= install_data_i;
    end
  end

endmodule

// File: rtl/pixel_word_cache.sv
// Pixel lookup front-end: coordinate-to-word translation, cache FSM, RAM fetch timing and stats.
// state   | meaning
// S_IDLE  | after reset, no result yet, request may be issued
// S_FETCH | RAM read in flight, waiting RD_LAT cycles for rdata
// S_DONE  | pixel valid (ready=1), request may be issued
module pixel_word_cache
  import pixel_cache_pkg::*;
#(
  parameter int IMG_W     = 640,
  parameter int IMG_H     = 480,
  parameter int COORD_W   = 10,
  parameter int WORD_W    = 8,
  parameter int ADDR_W    = 16,
  parameter int RD_LAT    = 1,
  parameter int NUM_LINES = 4,
  parameter int STAT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [COORD_W-1:0] x,
  input  logic [COORD_W-1:0] y,
  input  logic               request,
  input  logic               flush,
  output logic               pixel,
  output logic               ready,
  output logic [ADDR_W-1:0]  rdaddress,
  input  logic [WORD_W-1:0]  rdata,
  output logic [STAT_W-1:0]  hit_count,
  output logic [STAT_W-1:0]  miss_count
);

  localparam int IDX_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
  localparam int BIT_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int LAT_W = $clog2(RD_LAT + 1);

  state_e            state_q, state_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic [BIT_W-1:0]  bidx_q, bidx_d;
  logic              pixel_q, pixel_d;
  logic [ADDR_W-1:0] rdaddr_q, rdaddr_d;
  logic [STAT_W-1:0] hit_q, hit_d;
  logic [STAT_W-1:0] miss_q, miss_d;
  logic              pend_flush_q, pend_flush_d;

  logic              in_range;
  logic [ADDR_W-1:0] waddr;
  logic [BIT_W-1:0]  bidx_now;
  logic              ls_hit;
  logic [WORD_W-1:0] ls_data;
  logic              install;

  assign in_range = (32'(x) < IMG_W) && (32'(y) < IMG_H);
  assign waddr    = ADDR_W'(word_addr(32'(x), 32'(y), IMG_W, WORD_W));
  assign bidx_now = BIT_W'(bit_index(32'(x), WORD_W));

  pixel_cache_line_store #(
    .NUM_LINES(NUM_LINES),
    .WORD_W   (WORD_W),
    .ADDR_W   (ADDR_W),
    .IDX_W    (IDX_W)
  ) u_store (
    .clk_i         (clk),
    .rst_i         (reset),
    .lookup_tag_i  (waddr),
    .hit_o         (ls_hit),
    .hit_data_o    (ls_data),
    .flush_i       (flush),
    .install_i     (install),
    .install_idx_i (rr_q),
    .install_tag_i (rdaddr_q),
    .install_data_i(rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      lat_q        <= '0;
      rr_q         <= '0;
      bidx_q       <= '0;
      pixel_q      <= 1'b0;
      rdaddr_q     <= '0;
      hit_q        <= '0;
      miss_q       <= '0;
      pend_flush_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      lat_q        <= lat_d;
      rr_q         <= rr_d;
      bidx_q       <= bidx_d;
      pixel_q      <= pixel_d;
      rdaddr_q     <= rdaddr_d;
      hit_q        <= hit_d;
      miss_q       <= miss_d;
      pend_flush_q <= pend_flush_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    lat_d        = lat_q;
    rr_d         = rr_q;
    bidx_d       = bidx_q;
    pixel_d      = pixel_q;
    rdaddr_d     = rdaddr_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    pend_flush_d = pend_flush_q;
    install      = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (request) begin
          if (!in_range) begin
            state_d = S_DONE;
            pixel_d = 1'b0;
          end else if (ls_hit && !flush) begin
            // A same-cycle flush wins, so the lookup falls through to a miss.
            state_d = S_DONE;
            pixel_d = ls_data[bidx_now];
            if (hit_q != '1) hit_d = hit_q + STAT_W'(1);
          end else begin
            state_d      = S_FETCH;
            rdaddr_d     = waddr;
            lat_d        = LAT_W'(RD_LAT);
            bidx_d       = bidx_now;
            pend_flush_d = 1'b0;
            if (miss_q != '1) miss_d = miss_q + STAT_W'(1);
          end
        end
      end
      S_FETCH: begin
        if (flush) pend_flush_d = 1'b1;
        if (lat_q != '0) begin
          lat_d = lat_q - LAT_W'(1);
        end else begin
          state_d      = S_DONE;
          pixel_d      = rdata[bidx_q];
          pend_flush_d = 1'b0;
          // A flush seen anywhere during the fetch makes the fetched word stale.
          if (!(flush || pend_flush_q)) begin
            install = 1'b1;
            rr_d    = (rr_q == IDX_W'(NUM_LINES - 1)) ? '0 : rr_q + IDX_W'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign pixel      = pixel_q;
  assign ready      = (state_q == S_DONE);
  assign rdaddress  = rdaddr_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule
